pr_bridge_intc: RTL and testbench

System bridge between the CPU processor bus (PrAddr/PrRD/PrWD/PrBE/IOWrite) and two memory-mapped devices, plus a programmable interrupt controller that produces the CPU's HWInt[7:2].
- Address decode is combinational and same-cycle, because the CPU MEM stage has no wait state.
- The interrupt controller captures six sources (2 device, 4 external), applies mask and edge/level mode, and drives registered HWInt into CP0.

---
 rtl/pr_bridge_intc_pkg.sv | 48 ++++
 rtl/pr_intc_core.sv | 112 +++++++++++
 rtl/pr_bridge_intc.sv | 87 ++++++++
 tb/tb_pr_bridge_intc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_bridge_intc_pkg.sv
// Shared constants and helpers for the CPU-to-device bridge and its interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pr_bridge_intc_pkg;

  // PrAddr[31:4] match values for each 16-byte window
  localparam logic [27:0] DEV0_BASE = 28'h00007F0;
  localparam logic [27:0] DEV1_BASE = 28'h00007F1;
  localparam logic [27:0] INTC_BASE = 28'h00007F2;

  // INTC register word offsets (PrAddr[3:2])
  localparam logic [1:0] INTC_PEND = 2'd0;
  localparam logic [1:0] INTC_MASK = 2'd1;
  localparam logic [1:0] INTC_EDGE = 2'd2;
  localparam logic [1:0] INTC_ID   = 2'd3;

  // Interrupt source positions inside the six-bit source vector
  localparam int SRC_DEV0 = 0;
  localparam int SRC_DEV1 = 1;
  localparam int SRC_EXT0 = 2;
  localparam int NUM_SRC  = 6;

  // Which slave a bus address selects
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_DEV0 = 2'd1,
    TGT_DEV1 = 2'd2,
    TGT_INTC = 2'd3
  } tgt_e;

  // Contents of the ID register before zero extension
  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } intc_id_t;

  // Lowest-numbered active source wins; an empty vector reports idx 0, valid 0
  function automatic intc_id_t lowest_set(input logic [NUM_SRC-1:0] v);
    intc_id_t r;
    r.valid = |v;
    r.idx   = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) r.idx = 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/pr_intc_core.sv
// Interrupt controller: ext-irq synchronizer, MASK/EDGE/PEND registers, ID encoder, registered HWInt.
// Latency: dev irq -> PEND 1 cycle, -> hwint 2; ext irq -> PEND 3 cycles, -> hwint 4; register reads combinational.
// Backpressure: none; register writes complete in the cycle they are strobed.
module pr_intc_core
  import pr_bridge_intc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_we_i,
  input  logic [1:0]         reg_waddr_i,
  input  logic [5:0]         reg_wdata_i,
  input  logic [1:0]         reg_raddr_i,
  output logic [31:0]        reg_rdata_o,
  input  logic [1:0]         dev_irq_i,
  input  logic [3:0]         ext_irq_i,
  output logic [5:0]         hwint_o
);

  logic [3:0] sync1_q, sync2_q;
  logic [5:0] src;
  logic [5:0] src_d_q;
  logic [5:0] mask_q, mask_d;
  logic [5:0] edge_q, edge_d;
  logic [5:0] pend_q, pend_d;
  logic [5:0] hwint_q, hwint_d;
  logic [5:0] w1c;
  logic [5:0] edge_chg;
  intc_id_t   id;

  // Device irqs are already in this clock domain; external ones come out of the synchronizer
  always_comb begin
    src                             = '0;
    src[SRC_DEV0]                   = dev_irq_i[0];
    src[SRC_DEV1]                   = dev_irq_i[1];
    src[SRC_EXT0 +: 4]              = sync2_q;
  end

  // Register write decode: MASK/EDGE load, PEND clear mask, and which EDGE bits flip
  always_comb begin
    mask_d   = mask_q;
    edge_d   = edge_q;
    w1c      = '0;
    edge_chg = '0;
    if (reg_we_i) begin
      case (reg_waddr_i)
        INTC_PEND: w1c = reg_wdata_i;
        INTC_MASK: mask_d = reg_wdata_i;
        INTC_EDGE: begin
          edge_d   = reg_wdata_i;
          edge_chg = edge_q ^ reg_wdata_i;
        end
        default: ;
      endcase
    end
  end

  // Pending update: a mode change flushes the bit, a fresh edge beats a same-cycle clear
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (edge_chg[i]) begin
        pend_d[i] = 1'b0;
      end else if (edge_q[i]) begin
        pend_d[i] = (src[i] & ~src_d_q[i]) | (pend_q[i] & ~w1c[i]);
      end else begin
        pend_d[i] = src[i];
      end
    end
  end

  // Output stage sees the mask as of the previous edge
  always_comb begin
    hwint_d = pend_q & mask_q;
  end

  // Register readback, unused bits zero
  always_comb begin
    id          = lowest_set(pend_q & mask_q);
    reg_rdata_o = '0;
    case (reg_raddr_i)
      INTC_PEND: reg_rdata_o = {26'b0, pend_q};
      INTC_MASK: reg_rdata_o = {26'b0, mask_q};
      INTC_EDGE: reg_rdata_o = {26'b0, edge_q};
      INTC_ID:   reg_rdata_o = {28'b0, id};
      default:   reg_rdata_o = '0;
    endcase
  end

  // All controller state; reset drops every pending interrupt immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      src_d_q <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      pend_q  <= '0;
      hwint_q <= '0;
    end else begin
      sync1_q <= ext_irq_i;
      sync2_q <= sync1_q;
      src_d_q <= src;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      pend_q  <= pend_d;
      hwint_q <= hwint_d;
    end
  end

  assign hwint_o = hwint_q;

endmodule

// File: rtl/pr_bridge_intc.sv
// CPU processor-bus bridge to two devices plus interrupt controller driving HWInt[7:2].
// Latency: decode, read mux and device strobes combinational (same cycle); HWInt registered.
// Backpressure: none; the CPU MEM stage has no wait state so every access completes in its cycle.
module pr_bridge_intc #(
  parameter logic [27:0] DEV0_BASE = pr_bridge_intc_pkg::DEV0_BASE,
  parameter logic [27:0] DEV1_BASE = pr_bridge_intc_pkg::DEV1_BASE,
  parameter logic [27:0] INTC_BASE = pr_bridge_intc_pkg::INTC_BASE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] PrAddr,
  input  logic [31:0] PrWD,
  input  logic [3:0]  PrBE,
  input  logic        IOWrite,
  output logic [31:0] PrRD,
  output logic [5:0]  HWInt,
  output logic [1:0]  Dev0Addr,
  output logic [31:0] Dev0WD,
  output logic [3:0]  Dev0BE,
  output logic        Dev0WE,
  input  logic [31:0] Dev0RD,
  input  logic        Dev0Irq,
  output logic [1:0]  Dev1Addr,
  output logic [31:0] Dev1WD,
  output logic [3:0]  Dev1BE,
  output logic        Dev1WE,
  input  logic [31:0] Dev1RD,
  input  logic        Dev1Irq,
  input  logic [3:0]  ExtIrq
);

  import pr_bridge_intc_pkg::*;

  tgt_e        tgt;
  logic        intc_we;
  logic [31:0] intc_rdata;

  // Same-cycle window decode; the bases are distinct so at most one target matches
  always_comb begin
    tgt = TGT_NONE;
    if (PrAddr[31:4] == DEV0_BASE) begin
      tgt = TGT_DEV0;
    end else if (PrAddr[31:4] == DEV1_BASE) begin
      tgt = TGT_DEV1;
    end else if (PrAddr[31:4] == INTC_BASE) begin
      tgt = TGT_INTC;
    end
  end

  // Device side is pure passthrough; only the write strobe is qualified by the decode
  assign Dev0Addr = PrAddr[3:2];
  assign Dev0WD   = PrWD;
  assign Dev0BE   = PrBE;
  assign Dev0WE   = IOWrite & (tgt == TGT_DEV0);
  assign Dev1Addr = PrAddr[3:2];
  assign Dev1WD   = PrWD;
  assign Dev1BE   = PrBE;
  assign Dev1WE   = IOWrite & (tgt == TGT_DEV1);

  // Partial-word writes to the controller are dropped outright
  assign intc_we = IOWrite & (tgt == TGT_INTC) & (PrBE == 4'b1111);

  // Read data back to the CPU; unmapped space reads as zero
  always_comb begin
    PrRD = '0;
    case (tgt)
      TGT_DEV0: PrRD = Dev0RD;
      TGT_DEV1: PrRD = Dev1RD;
      TGT_INTC: PrRD = intc_rdata;
      default:  PrRD = '0;
    endcase
  end

  pr_intc_core u_intc (
    .clk         (clk),
    .rst         (rst),
    .reg_we_i    (intc_we),
    .reg_waddr_i (PrAddr[3:2]),
    .reg_wdata_i (PrWD[5:0]),
    .reg_raddr_i (PrAddr[3:2]),
    .reg_rdata_o (intc_rdata),
    .dev_irq_i   ({Dev1Irq, Dev0Irq}),
    .ext_irq_i   (ExtIrq),
    .hwint_o     (HWInt)
  );

endmodule

// File: tb/tb_pr_bridge_intc.sv
// Directed bench for pr_bridge_intc: expectations queued as stimulus is driven, popped at each observation.
// Latency: inputs change 2 time units after a rising edge, outputs sampled between edges.
// Backpressure: n/a.
module tb_pr_bridge_intc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:2] PrAddr;
  logic [31:0] PrWD;
  logic [3:0]  PrBE;
  logic        IOWrite;
  logic [31:0] PrRD;
  logic [5:0]  HWInt;
  logic [1:0]  Dev0Addr, Dev1Addr;
  logic [31:0] Dev0WD, Dev1WD;
  logic [3:0]  Dev0BE, Dev1BE;
  logic        Dev0WE, Dev1WE;
  logic [31:0] Dev0RD, Dev1RD;
  logic        Dev0Irq, Dev1Irq;
  logic [3:0]  ExtIrq;

  always #10 clk = ~clk;

  pr_bridge_intc dut (
    .clk      (clk),
    .rst      (rst),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .PrBE     (PrBE),
    .IOWrite  (IOWrite),
    .PrRD     (PrRD),
    .HWInt    (HWInt),
    .Dev0Addr (Dev0Addr),
    .Dev0WD   (Dev0WD),
    .Dev0BE   (Dev0BE),
    .Dev0WE   (Dev0WE),
    .Dev0RD   (Dev0RD),
    .Dev0Irq  (Dev0Irq),
    .Dev1Addr (Dev1Addr),
    .Dev1WD   (Dev1WD),
    .Dev1BE   (Dev1BE),
    .Dev1WE   (Dev1WE),
    .Dev1RD   (Dev1RD),
    .Dev1Irq  (Dev1Irq),
    .ExtIrq   (ExtIrq)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  localparam logic [31:0] A_PEND = 32'h0000_7F20;
  localparam logic [31:0] A_MASK = 32'h0000_7F24;
  localparam logic [31:0] A_EDGE = 32'h0000_7F28;
  localparam logic [31:0] A_ID   = 32'h0000_7F2C;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty: observed %h with no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_read(input string tag, input logic [31:0] a, input logic [31:0] exp_v);
    expect_val(tag, exp_v);
    PrAddr  = a[31:2];
    IOWrite = 1'b0;
    PrBE    = 4'hF;
    #1;
    compare(PrRD);
  endtask

  task automatic check_hw(input string tag, input logic [5:0] exp_v);
    expect_val(tag, {26'b0, exp_v});
    compare({26'b0, HWInt});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    PrAddr  = a[31:2];
    PrWD    = d;
    PrBE    = be;
    IOWrite = 1'b1;
    step();
    IOWrite = 1'b0;
    PrBE    = 4'hF;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    rst     = 1'b1;
    PrAddr  = '0;
    PrWD    = '0;
    PrBE    = 4'hF;
    IOWrite = 1'b0;
    Dev0RD  = 32'hA5A5_0001;
    Dev1RD  = 32'h1234_5678;
    Dev0Irq = 1'b0;
    Dev1Irq = 1'b0;
    ExtIrq  = 4'h0;

    // Combinational paths are live during reset
    #3;
    check_read("rd_dev0_in_reset", 32'h0000_7F00, 32'hA5A5_0001);
    expect_val("dev0we_no_iowrite", 32'd0);
    compare({31'b0, Dev0WE});
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state of the controller
    check_read("mask_reset", A_MASK, 32'd0);
    check_read("edge_reset", A_EDGE, 32'd0);
    check_read("pend_reset", A_PEND, 32'd0);
    check_read("id_reset",   A_ID,   32'd0);
    check_hw("hwint_reset", 6'd0);

    // Device write strobes and read mux
    a       = 32'h0000_7F04;
    PrAddr  = a[31:2];
    PrWD    = 32'hDEAD_BEEF;
    PrBE    = 4'hF;
    IOWrite = 1'b1;
    #1;
    expect_val("dev0we_hit", 32'd1);
    compare({31'b0, Dev0WE});
    expect_val("dev0addr", 32'd1);
    compare({30'b0, Dev0Addr});
    expect_val("dev0wd", 32'hDEAD_BEEF);
    compare(Dev0WD);
    expect_val("dev1we_miss", 32'd0);
    compare({31'b0, Dev1WE});
    step();
    IOWrite = 1'b0;
    check_read("rd_dev1", 32'h0000_7F14, 32'h1234_5678);
    check_read("rd_unmapped", 32'h0000_8000, 32'd0);

    // Level mode, device 1
    bus_write(A_MASK, 32'h0000_003F, 4'hF);
    Dev1Irq = 1'b1;
    step();
    check_read("lvl_pend_set", A_PEND, 32'h02);
    check_hw("lvl_hw_not_yet", 6'h00);
    check_read("lvl_id", A_ID, 32'h09);
    step();
    check_hw("lvl_hw_set", 6'h02);
    Dev1Irq = 1'b0;
    step();
    check_hw("lvl_hw_hold_one", 6'h02);
    step();
    check_hw("lvl_hw_clear", 6'h00);

    // Edge mode, external irq through synchronizer
    bus_write(A_EDGE, 32'h0000_003F, 4'hF);
    ExtIrq = 4'b0010;
    step();
    step();
    step();
    check_read("ext_pend_set", A_PEND, 32'h08);
    check_hw("ext_hw_not_yet", 6'h00);
    step();
    check_hw("ext_hw_set", 6'h08);
    ExtIrq = 4'b0000;
    step();
    step();
    check_hw("ext_hw_held", 6'h08);
    check_read("ext_id", A_ID, 32'h0B);
    bus_write(A_PEND, 32'h0000_0008, 4'hF);
    check_read("ext_w1c_pend", A_PEND, 32'h00);
    check_hw("ext_w1c_hw_lag", 6'h08);
    step();
    check_hw("ext_w1c_hw_clear", 6'h00);

    // New edge beats a simultaneous clear
    Dev0Irq = 1'b1;
    step();
    Dev0Irq = 1'b0;
    step();
    check_read("edge0_pend", A_PEND, 32'h01);
    Dev0Irq = 1'b1;
    bus_write(A_PEND, 32'h0000_0001, 4'hF);
    check_read("edge_wins_w1c", A_PEND, 32'h01);
    bus_write(A_PEND, 32'h0000_0001, 4'hF);
    check_read("w1c_no_edge", A_PEND, 32'h00);

    // Changing a mode bit flushes it for one cycle
    Dev0Irq = 1'b0;
    step();
    Dev0Irq = 1'b1;
    step();
    check_read("edge0_pend_again", A_PEND, 32'h01);
    bus_write(A_EDGE, 32'h0000_003E, 4'hF);
    check_read("mode_change_flush", A_PEND, 32'h00);
    step();
    check_read("level_resume", A_PEND, 32'h01);
    bus_write(A_PEND, 32'h0000_0001, 4'hF);
    check_read("level_ignores_w1c", A_PEND, 32'h01);
    Dev0Irq = 1'b0;
    step();
    check_read("level_follow_low", A_PEND, 32'h00);

    // Partial byte enables leave registers alone
    bus_write(A_MASK, 32'h0000_0000, 4'hF);
    bus_write(A_MASK, 32'h0000_003F, 4'h1);
    check_read("mask_be_partial", A_MASK, 32'h00);

    // Asynchronous reset with an interrupt in flight
    bus_write(A_MASK, 32'h0000_003F, 4'hF);
    Dev1Irq = 1'b1;
    step();
    step();
    check_hw("pre_reset_hw", 6'h02);
    rst = 1'b1;
    #1;
    check_hw("reset_hw", 6'h00);
    check_read("reset_pend", A_PEND, 32'h00);
    check_read("reset_mask", A_MASK, 32'h00);
    check_read("reset_edge", A_EDGE, 32'h00);

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
